micro_sequencer: RTL
====================

Name: micro_sequencer

Overview:
- Multi-cycle control sequencer for the processor core.
- Accepts one fetched 32-bit instruction at a time and decodes it to a 6-bit micro-address.
- Drives that address into the micro-instruction memory and registers the returned 16-bit control word toward the datapath.
- Holds the control word across multi-cycle operations: data-memory access, iterative MUL, and the MEMCOPY loop of alternating read/write phases.

Parameters:
WIDTH, 16, control word width (ALUSrc[0] … MemAcc[15:13])
ADDR_W, 6, micro-address width
CNT_W, 8, MEMCOPY word-count width

Ports:
clk  in  1  single system clock
reset  in  1  reset, synchronous, active-high
instr_valid  in  1  fetched instruction available
instr  in  32  RV32 instruction
instr_ready  out  1  sequencer accepts instr this cycle
uaddr  out  ADDR_W  micro-address to micro-instruction memory (registered)
udata  in  WIDTH  control word, combinational from memory
ctrl  out  WIDTH  registered control word to datapath
ctrl_valid  out  1  ctrl is live this cycle
mem_ready  in  1  data-memory access complete
mul_done  in  1  multiplier result ready
copy_count  in  CNT_W  MEMCOPY word count, sampled at accept
copy_phase  out  1  0 = MEMCOPY read phase, 1 = write phase
illegal  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (port reset). All outputs are registered.
- Reset values: state FETCH, uaddr=0, ctrl=0, ctrl_valid=0, copy_phase=0, illegal=0, remaining count=0.
- Reset mid-operation: abandon the current operation. Outputs take reset values the cycle after reset is sampled high. No partial MEMCOPY resume.
- States: FETCH, LOOKUP, EXEC, MEMWAIT, MULWAIT, COPY_RD, COPY_WR.
- FETCH:
  - instr_ready=1.
  - On instr_valid: register decoded uaddr and go to LOOKUP. For MEMCOPY, also latch copy_count.
  - Undecodable instruction: pulse illegal, stay in FETCH, ctrl unchanged.
- Decode (constant table):
  - R add/sub/sll/slt/sltu/xor/srl/sra/or/and → 0..9.
  - I addi/slli/slti/sltiu/xori/srli/srai/ori/andi → 10..18.
  - lw/lh/lb/lhu/lbu → 19..23.
  - sw/sh/sb → 24..26.
  - beq 27, bne 28, blt/bge 29, bltu/bgeu 33, jalr 30.
  - MUL (funct7=0000001, funct3=000) → 31.
  - MEMCOPY (opcode 0001011) → 32.
  - Anything else is illegal.
- LOOKUP: ctrl <= udata, then dispatch:
  - MUL → MULWAIT.
  - MEMCOPY with count 0 → FETCH, no ctrl_valid.
  - MEMCOPY with count > 0 → COPY_RD.
  - MemRead or MemWrite bit set → MEMWAIT.
  - Otherwise → EXEC.
- EXEC: ctrl_valid=1 for exactly one cycle, then FETCH.
  - Latency: accept at cycle N → ctrl_valid at N+2 → instr_ready at N+3.
- MEMWAIT: ctrl_valid=1 held until a cycle with mem_ready=1 (including the entry cycle), then FETCH.
- MULWAIT: ctrl_valid=1 held until mul_done=1, then FETCH.
- COPY_RD: ctrl_valid=1, copy_phase=0. On mem_ready → COPY_WR.
- COPY_WR: ctrl_valid=1, copy_phase=1. On mem_ready, decrement remaining count; → FETCH if it reaches 0, else → COPY_RD.
- Ignored inputs:
  - mem_ready outside MEMWAIT/COPY_*.
  - mul_done outside MULWAIT.
  - instr_valid outside FETCH; instr is held by the fetch stage.
- Count arithmetic: unsigned CNT_W. Maximum 2^CNT_W−1 words, no wrap.

Decomposition:
- Package micro_seq_pkg:
  - state enum.
  - opcode/funct constants.
  - micro-address constants (UA_ADD … UA_MEMCOPY).
  - control-word bit-index localparams (MEMREAD=4, MEMWRITE=5).
- Sub-module micro_decode: combinational instr → {uaddr, kind, illegal}. The FSM and counter stay in micro_sequencer.

Test Plan:
- add (instr 0x00208033), instr_valid at cycle 0 → uaddr=0 at cycle 1; ctrl=16'b000_100_0000_000_000 with ctrl_valid high at cycle 2 only; instr_ready at cycle 3.
- lw, mem_ready asserted 3 cycles after MEMWAIT entry → ctrl_valid high 4 cycles, ctrl[15:13]=110, return to FETCH.
- MUL, mul_done after 5 cycles → uaddr=31, ctrl_valid high 6 cycles, no early exit on a stray mem_ready.
- MEMCOPY with copy_count=3, mem_ready every cycle → copy_phase sequence 0,1,0,1,0,1, then FETCH; copy_count=0 → no ctrl_valid, instr_ready 2 cycles after accept.
- Opcode 0x7F → illegal pulse of 1 cycle, ctrl_valid stays 0, next instruction accepted the following cycle.
- Reset asserted during COPY_WR of word 2 → next cycle all outputs at reset values; a following add executes normally.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: sequencer states, RV32 decode constants, micro-address map and control-word bit layout
package micro_seq_pkg;
  typedef enum logic [2:0] {S_FETCH, S_LOOKUP, S_EXEC, S_MEMWAIT, S_MULWAIT, S_COPY_RD, S_COPY_WR} state_t;
  typedef enum logic [1:0] {K_NORM, K_MUL, K_COPY} kind_t;
  localparam int MEMREAD = 4;
  localparam int MEMWRITE = 5;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_COPY = 7'b0001011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;
  localparam int UA_NONE = -1;
  localparam int UA_ADD = 0, UA_SUB = 1, UA_SLL = 2, UA_SLT = 3, UA_SLTU = 4;
  localparam int UA_XOR = 5, UA_SRL = 6, UA_SRA = 7, UA_OR = 8, UA_AND = 9;
  localparam int UA_ADDI = 10, UA_SLLI = 11, UA_SLTI = 12, UA_SLTIU = 13, UA_XORI = 14;
  localparam int UA_SRLI = 15, UA_SRAI = 16, UA_ORI = 17, UA_ANDI = 18;
  localparam int UA_LW = 19, UA_LH = 20, UA_LB = 21, UA_LHU = 22, UA_LBU = 23;
  localparam int UA_SW = 24, UA_SH = 25, UA_SB = 26;
  localparam int UA_BEQ = 27, UA_BNE = 28, UA_BLT = 29, UA_JALR = 30;
  localparam int UA_MUL = 31, UA_MEMCOPY = 32, UA_BLTU = 33;
  // funct3-indexed tables; UA_NONE marks encodings with no micro-routine
  localparam int R_UA [8] = '{UA_ADD, UA_SLL, UA_SLT, UA_SLTU, UA_XOR, UA_SRL, UA_OR, UA_AND};
  localparam int I_UA [8] = '{UA_ADDI, UA_SLLI, UA_SLTI, UA_SLTIU, UA_XORI, UA_SRLI, UA_ORI, UA_ANDI};
  localparam int LD_UA [8] = '{UA_LB, UA_LH, UA_LW, UA_NONE, UA_LBU, UA_LHU, UA_NONE, UA_NONE};
  localparam int ST_UA [8] = '{UA_SB, UA_SH, UA_SW, UA_NONE, UA_NONE, UA_NONE, UA_NONE, UA_NONE};
  localparam int BR_UA [8] = '{UA_BEQ, UA_BNE, UA_NONE, UA_NONE, UA_BLT, UA_BLT, UA_BLTU, UA_BLTU};
endpackage

// File: rtl/micro_decode.sv
// micro_decode: combinational RV32 instruction to micro-address, operation kind and illegal flag
module micro_decode
  import micro_seq_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] uaddr,
  output kind_t             kind,
  output logic              illegal
);
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic w_unused;
  int w_ua;
  assign w_op = instr[6:0];
  assign w_f3 = instr[14:12];
  assign w_f7 = instr[31:25];
  assign w_unused = ^{instr[24:15], instr[11:7]};
  always_comb begin
    w_ua = UA_NONE;
    kind = K_NORM;
    case (w_op)
      OP_R: begin
        if (w_f7 == F7_MUL) begin
          w_ua = (w_f3 == 3'd0) ? UA_MUL : UA_NONE;
          kind = K_MUL;
        end else if (w_f7 == F7_BASE) w_ua = R_UA[w_f3];
        else if (w_f7 == F7_ALT) w_ua = (w_f3 == 3'd0) ? UA_SUB : (w_f3 == 3'd5) ? UA_SRA : UA_NONE;
      end
      OP_I: w_ua = (w_f3 == 3'd1) ? ((w_f7 == F7_BASE) ? UA_SLLI : UA_NONE) :
                   (w_f3 == 3'd5) ? ((w_f7 == F7_BASE) ? UA_SRLI : (w_f7 == F7_ALT) ? UA_SRAI : UA_NONE) :
                   I_UA[w_f3];
      OP_LOAD: w_ua = LD_UA[w_f3];
      OP_STORE: w_ua = ST_UA[w_f3];
      OP_BRANCH: w_ua = BR_UA[w_f3];
      OP_JALR: w_ua = (w_f3 == 3'd0) ? UA_JALR : UA_NONE;
      OP_COPY: begin
        w_ua = UA_MEMCOPY;
        kind = K_COPY;
      end
      default: w_ua = UA_NONE;
    endcase
    illegal = (w_ua < 0);
    uaddr = illegal ? '0 : ADDR_W'(w_ua);
  end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: fetch/decode handshake, micro-memory lookup and control-word hold across multi-cycle ops
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 6,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] uaddr,
  input  logic [WIDTH-1:0]  udata,
  output logic [WIDTH-1:0]  ctrl,
  output logic              ctrl_valid,
  input  logic              mem_ready,
  input  logic              mul_done,
  input  logic [CNT_W-1:0]  copy_count,
  output logic              copy_phase,
  output logic              illegal
);
  state_t r_state, w_next;
  kind_t r_kind, w_dec_kind;
  logic [ADDR_W-1:0] r_uaddr, w_dec_uaddr;
  logic [WIDTH-1:0] r_ctrl;
  logic [CNT_W-1:0] r_count;
  logic r_instr_ready, r_ctrl_valid, r_copy_phase, r_illegal;
  logic w_dec_ill, w_accept;
  micro_decode #(.ADDR_W(ADDR_W)) u_decode (
    .instr  (instr),
    .uaddr  (w_dec_uaddr),
    .kind   (w_dec_kind),
    .illegal(w_dec_ill)
  );
  assign w_accept = (r_state == S_FETCH) && instr_valid && !w_dec_ill;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = w_accept ? S_LOOKUP : S_FETCH;
      S_LOOKUP: w_next = (r_kind == K_MUL) ? S_MULWAIT :
                         (r_kind == K_COPY) ? ((r_count == '0) ? S_FETCH : S_COPY_RD) :
                         (udata[MEMREAD] || udata[MEMWRITE]) ? S_MEMWAIT : S_EXEC;
      S_EXEC: w_next = S_FETCH;
      S_MEMWAIT: w_next = mem_ready ? S_FETCH : S_MEMWAIT;
      S_MULWAIT: w_next = mul_done ? S_FETCH : S_MULWAIT;
      S_COPY_RD: w_next = mem_ready ? S_COPY_WR : S_COPY_RD;
      S_COPY_WR: w_next = !mem_ready ? S_COPY_WR : (r_count == CNT_W'(1)) ? S_FETCH : S_COPY_RD;
      default: w_next = S_FETCH;
    endcase
  end
  // status outputs are registered from the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_kind <= K_NORM;
      r_uaddr <= '0;
      r_ctrl <= '0;
      r_count <= '0;
      r_instr_ready <= 1'b1;
      r_ctrl_valid <= 1'b0;
      r_copy_phase <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_illegal <= (r_state == S_FETCH) && instr_valid && w_dec_ill;
      if (w_accept) begin
        r_uaddr <= w_dec_uaddr;
        r_kind <= w_dec_kind;
        if (w_dec_kind == K_COPY) r_count <= copy_count;
      end
      if (r_state == S_LOOKUP) r_ctrl <= udata;
      if (r_state == S_COPY_WR && mem_ready) r_count <= r_count - 1'b1;
      r_instr_ready <= (w_next == S_FETCH);
      r_ctrl_valid <= (w_next != S_FETCH) && (w_next != S_LOOKUP);
      r_copy_phase <= (w_next == S_COPY_WR);
    end
  end
  assign instr_ready = r_instr_ready;
  assign uaddr = r_uaddr;
  assign ctrl = r_ctrl;
  assign ctrl_valid = r_ctrl_valid;
  assign copy_phase = r_copy_phase;
  assign illegal = r_illegal;
endmodule
